work_transmit: RTL and testbench



---
 rtl/serial_pkg.sv | 17 +
 rtl/work_transmit_uart_tx_byte.sv | 95 +++++++++
 rtl/work_transmit.sv | 126 ++++++++++++
 tb/tb_work_transmit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the work-unit serial link.
// Byte order and counts are common to the transmit and receive sides.
package serial_pkg;

  localparam int UART_FRAME_BITS = 10;
  localparam int WORK_BYTES      = 64;
  localparam int WORK_BITS       = 512;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_e;

endpackage

// File: rtl/work_transmit_uart_tx_byte.sv
// 8N1 byte serializer: baud counter, start/data/stop sequencing, TxD.
// A start during the last stop cycle chains the next byte with no gap.
module uart_tx_byte
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       TxD,
  output logic       byte_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end   = (baud_q == BAUD_MAX);
  assign byte_done = (state_q == STOP) && bit_end;
  assign TxD       = txd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (start) begin
          state_d = START;
          sh_d    = tx_byte;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            txd_d = sh_q[1];
            sh_d  = sh_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (start) begin
            state_d = START;
            sh_d    = tx_byte;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/work_transmit.sv
// Serializes a 512-bit work unit {midstate, data2} as 64 UART bytes,
// MSB byte first, followed by an idle-high inter-frame gap.
module work_transmit
  import serial_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int GAP_BITS  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         send,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  output logic         TxD,
  output logic         busy,
  output logic         done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_MAX =
    GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e               state_q, state_d;
  logic [WORK_BITS-1:0] frame_q, frame_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic       accept;
  logic       last_byte;
  logic       tx_start;
  logic       byte_done;
  logic [7:0] tx_byte;

  // frame_q holds the bytes not yet handed to the serializer
  assign accept    = (state_q == IDLE) && send;
  assign last_byte = (cnt_q == 6'(WORK_BYTES - 1));
  assign tx_start  = accept ||
                     ((state_q == DATA) && byte_done && !last_byte);
  assign tx_byte   = accept ? midstate[255:248]
                            : frame_q[WORK_BITS-1 -: 8];

  assign busy = busy_q;
  assign done = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (tx_start),
    .tx_byte  (tx_byte),
    .TxD      (TxD),
    .byte_done(byte_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DATA;
          frame_d = {midstate[247:0], data2, 8'h00};
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      DATA: begin
        if (byte_done) begin
          if (!last_byte) begin
            frame_d = frame_q << 8;
            cnt_d   = cnt_q + 1'b1;
          end else if (GAP_CYC == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = '0;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = IDLE;
          gap_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_work_transmit.sv
// Self-checking bench for work_transmit: line waveform model, UART
// decode, table vectors and multi-cycle corner sequences.
module tb_work_transmit;

  localparam int C        = 10;
  localparam int G        = 2;
  localparam int LINE_CYC = 640 * C;
  localparam int BUSY_CYC = (640 + G) * C;
  localparam int TR       = 1 << 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         send = 1'b0;
  logic [255:0] midstate = '0;
  logic [255:0] data2 = '0;
  logic         TxD, busy, done;

  int cyc = 0;
  int pass_cnt = 0;
  int total = 0;

  bit txd_tr [TR];
  bit busy_tr[TR];
  bit done_tr[TR];

  typedef struct {
    int r;
    bit txd;
    bit busy;
    bit done;
  } vec_t;

  work_transmit #(
    .CLK_FREQ (1000),
    .BAUD_RATE(100),
    .GAP_BITS (G)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .send    (send),
    .midstate(midstate),
    .data2   (data2),
    .TxD     (TxD),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < TR) begin
      txd_tr[cyc]  = TxD;
      busy_tr[cyc] = busy;
      done_tr[cyc] = done;
    end
  end

  initial begin
    #1500000;
    $display("FAIL timeout: got no summary, expected finish");
    $fatal(1);
  end

  task automatic chk(string name, longint got, longint exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Ideal line level t cycles after the accepting edge
  function automatic bit exp_txd(logic [511:0] f, int t);
    int b, n, p;
    logic [7:0] by;
    if (t < 0 || t >= LINE_CYC) return 1'b1;
    b  = t / C;
    n  = b / 10;
    p  = b % 10;
    by = f[511 - 8*n -: 8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  function automatic int wave_errs(int a, logic [511:0] f);
    int e = 0;
    for (int t = -1; t <= BUSY_CYC; t++) begin
      if (txd_tr[a+t] != exp_txd(f, t)) e++;
      if (busy_tr[a+t] != (t >= 0 && t < BUSY_CYC)) e++;
      if (t >= 0 && done_tr[a+t] != (t == BUSY_CYC)) e++;
    end
    return e;
  endfunction

  // Mid-bit sampling UART monitor
  function automatic logic [511:0] decode(int a);
    logic [511:0] f = '0;
    for (int n = 0; n < 64; n++)
      for (int k = 0; k < 8; k++)
        f[504 - 8*n + k] = txd_tr[a + (10*n + 1 + k)*C + C/2];
    return f;
  endfunction

  function automatic int frame_errs(int a);
    int e = 0;
    for (int n = 0; n < 64; n++) begin
      if (txd_tr[a + 10*n*C + C/2] != 1'b0) e++;
      if (txd_tr[a + (10*n + 9)*C + C/2] != 1'b1) e++;
    end
    return e;
  endfunction

  function automatic int byte_errs(logic [511:0] g, logic [511:0] f);
    int e = 0;
    for (int n = 0; n < 64; n++)
      if (g[511 - 8*n -: 8] !== f[511 - 8*n -: 8]) e++;
    return e;
  endfunction

  function automatic int idle_errs(int from, int len);
    int e = 0;
    for (int i = from; i < from + len; i++)
      if (txd_tr[i] != 1'b1 || busy_tr[i] || done_tr[i]) e++;
    return e;
  endfunction

  task automatic send_pulse(input logic [255:0] ms,
                            input logic [255:0] d2,
                            output int a);
    @(negedge clk);
    midstate = ms;
    data2    = d2;
    send     = 1'b1;
    @(negedge clk);
    a    = cyc;
    send = 1'b0;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_frame(string tag, int a, logic [511:0] f);
    chk({tag, "_wave"}, wave_errs(a, f), 0);
    chk({tag, "_framing"}, frame_errs(a), 0);
    chk({tag, "_bytes"}, byte_errs(decode(a), f), 0);
  endtask

  initial begin
    vec_t         tbl[16];
    logic [255:0] ms, d2, ms2, d2b;
    int           a, a2, e, nb, nd;

    tbl[0]  = '{0,    1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,    1'b0, 1'b1, 1'b0};
    tbl[2]  = '{10,   1'b0, 1'b1, 1'b0};
    tbl[3]  = '{11,   1'b0, 1'b1, 1'b0};
    tbl[4]  = '{91,   1'b1, 1'b1, 1'b0};
    tbl[5]  = '{101,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{111,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{121,  1'b0, 1'b1, 1'b0};
    tbl[8]  = '{221,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{6361, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{6371, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{6391, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{6401, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{6420, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{6421, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{6422, 1'b1, 1'b0, 1'b0};

    // reset and idle line
    repeat (3) @(negedge clk);
    chk("reset_txd", TxD, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    e = 0;
    repeat (1000) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0 || done !== 1'b0) e++;
    end
    chk("idle_1000", e, 0);

    // counting-pattern frame through the vector table
    for (int i = 0; i < 32; i++) begin
      ms[255 - 8*i -: 8] = 8'(i);
      d2[255 - 8*i -: 8] = 8'(32 + i);
    end
    send_pulse(ms, d2, a);
    wait_until(a + BUSY_CYC + 3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("vec_r%0d_txd", tbl[i].r),
          txd_tr[a + tbl[i].r - 1], tbl[i].txd);
      chk($sformatf("vec_r%0d_busy", tbl[i].r),
          busy_tr[a + tbl[i].r - 1], tbl[i].busy);
      chk($sformatf("vec_r%0d_done", tbl[i].r),
          done_tr[a + tbl[i].r - 1], tbl[i].done);
    end
    check_frame("count", a, {ms, d2});
    nb = 0;
    nd = 0;
    for (int i = a - 1; i <= a + BUSY_CYC + 1; i++) begin
      nb += int'(busy_tr[i]);
      nd += int'(done_tr[i]);
    end
    chk("count_busy_cycles", nb, BUSY_CYC);
    chk("count_done_pulses", nd, 1);

    // random work units against the line model
    for (int j = 0; j < 2; j++) begin
      ms = rnd256();
      d2 = rnd256();
      send_pulse(ms, d2, a);
      wait_until(a + BUSY_CYC + 3);
      check_frame($sformatf("rand%0d", j), a, {ms, d2});
    end

    // input change and extra send while busy
    ms = rnd256();
    d2 = rnd256();
    send_pulse(ms, d2, a);
    wait_until(a + 99);
    midstate = rnd256();
    data2    = rnd256();
    wait_until(a + 2999);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_until(a + BUSY_CYC + 203);
    check_frame("ignore", a, {ms, d2});
    chk("ignore_no_extra", idle_errs(a + BUSY_CYC + 1, 200), 0);

    // send held high: back-to-back frames
    ms  = rnd256();
    d2  = rnd256();
    ms2 = rnd256();
    d2b = rnd256();
    @(negedge clk);
    midstate = ms;
    data2    = d2;
    send     = 1'b1;
    @(negedge clk);
    a = cyc;
    wait_until(a + 99);
    midstate = ms2;
    data2    = d2b;
    a2 = a + BUSY_CYC + 1;
    wait_until(a2);
    send = 1'b0;
    wait_until(a2 + BUSY_CYC + 203);
    check_frame("held1", a, {ms, d2});
    chk("held_gap_txd", txd_tr[a + BUSY_CYC], 1);
    chk("held_restart_txd", txd_tr[a2], 0);
    chk("held_restart_busy", busy_tr[a2], 1);
    check_frame("held2", a2, {ms2, d2b});
    chk("held_stop", idle_errs(a2 + BUSY_CYC + 1, 200), 0);

    // reset in the middle of a data bit
    ms = rnd256();
    d2 = rnd256();
    send_pulse(ms, d2, a);
    wait_until(a + 2344);
    reset = 1'b1;
    #1;
    chk("midreset_txd", TxD, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    e = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || TxD !== 1'b1) e++;
    end
    reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || TxD !== 1'b1) e++;
    end
    chk("midreset_quiet", e, 0);
    ms = rnd256();
    d2 = rnd256();
    send_pulse(ms, d2, a);
    wait_until(a + BUSY_CYC + 3);
    check_frame("after_reset", a, {ms, d2});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
